// File: rtl/comparador_serial_ctrl.sv
// MSB-first serial magnitude comparator with a start/busy/done handshake.
// One operand bit pair per clock; the first differing bit decides the result.
module comparador_serial_ctrl #(
  parameter int K = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inicio,
  input  logic [K-1:0] A_valor,
  input  logic [K-1:0] B_valor,
  output logic         ocupado,
  output logic         listo,
  output logic         A_mayor,
  output logic         B_mayor,
  output logic         iguales
);
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {ESPERA = 2'd0, COMPARA = 2'd1, FIN = 2'd2} estado_t;

  estado_t         estado;
  logic [K-1:0]    regA, regB;
  logic [IW-1:0]   idx;
  logic            bit_a, bit_b;

  assign bit_a = regA[idx];
  assign bit_b = regB[idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado  <= ESPERA;
      regA    <= '0;
      regB    <= '0;
      idx     <= '0;
      ocupado <= 1'b0;
      listo   <= 1'b0;
      A_mayor <= 1'b0;
      B_mayor <= 1'b0;
      iguales <= 1'b0;
    end else begin
      case (estado)
        ESPERA: begin
          listo <= 1'b0;
          if (inicio) begin
            regA    <= A_valor;
            regB    <= B_valor;
            idx     <= IW'(K - 1);
            A_mayor <= 1'b0;
            B_mayor <= 1'b0;
            iguales <= 1'b0;
            ocupado <= 1'b1;
            estado  <= COMPARA;
          end
        end
        COMPARA: begin
          // listo is raised on the decision edge so it is high exactly during FIN
          if (bit_a != bit_b) begin
            A_mayor <= bit_a;
            B_mayor <= bit_b;
            listo   <= 1'b1;
            estado  <= FIN;
          end else if (idx == '0) begin
            iguales <= 1'b1;
            listo   <= 1'b1;
            estado  <= FIN;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        FIN: begin
          listo   <= 1'b0;
          ocupado <= 1'b0;
          estado  <= ESPERA;
        end
        default: begin
          listo   <= 1'b0;
          ocupado <= 1'b0;
          estado  <= ESPERA;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_comparador_serial_ctrl.sv
// Scoreboard bench: expected flags/latency queued at acceptance, checked on listo.
module tb_comparador_serial_ctrl;
  localparam int K = 5;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         inicio = 1'b0;
  logic [K-1:0] A_valor = '0, B_valor = '0;
  logic         ocupado, listo, A_mayor, B_mayor, iguales;

  comparador_serial_ctrl #(.K(K)) dut (
    .clk(clk), .reset_n(reset_n), .inicio(inicio),
    .A_valor(A_valor), .B_valor(B_valor),
    .ocupado(ocupado), .listo(listo),
    .A_mayor(A_mayor), .B_mayor(B_mayor), .iguales(iguales)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] flags;
    int         lat;
    int         t0;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [2:0] last_exp = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [K-1:0] a, input logic [K-1:0] b);
    exp_t m;
    m.flags = (a > b) ? 3'b100 : (b > a) ? 3'b010 : 3'b001;
    m.lat = K;
    for (int i = 0; i < K; i++) if (a[i] != b[i]) m.lat = K - i;
    m.t0 = 0;
    return m;
  endfunction

  // Every listo cycle must match the oldest outstanding comparison
  always @(negedge clk) begin
    if (listo) begin
      if (sb.size() == 0) chk("spurious_listo", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("flags", {29'd0, A_mayor, B_mayor, iguales}, {29'd0, e.flags});
        chk("latency", cyc - e.t0, e.lat);
        chk("onehot", $countones({A_mayor, B_mayor, iguales}), 1);
        chk("ocupado_in_fin", ocupado, 1);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (ocupado && n < 50);
    if (n >= 50) chk("timeout_idle", 0, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk); n++;
    end
    if (sb.size() != 0) begin
      chk("timeout_listo", 0, 1);
      sb.delete();
    end
  endtask

  // Drives one comparison; returns right after the acceptance edge (E0 + 1)
  task automatic start(input logic [K-1:0] a, input logic [K-1:0] b);
    exp_t e;
    wait_idle();
    chk("hold", {A_mayor, B_mayor, iguales}, last_exp);
    A_valor = a; B_valor = b; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    e = model(a, b);
    e.t0 = cyc;
    sb.push_back(e);
    last_exp = e.flags;
    chk("ocupado_after_e0", ocupado, 1);
    chk("flags_clear_after_e0", {A_mayor, B_mayor, iguales}, 0);
  endtask

  task automatic run(input logic [K-1:0] a, input logic [K-1:0] b);
    start(a, b);
    wait_done();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_listo", listo, 0);
    chk("rst_flags", {A_mayor, B_mayor, iguales}, 0);
    reset_n = 1'b1;

    run(5'b11100, 5'b01101);
    run(5'b10001, 5'b10110);
    run(5'b01100, 5'b10001);
    run(5'b10101, 5'b10100);
    run(5'b10101, 5'b10101);

    // Operand and start isolation: change A and re-pulse inicio while busy
    start(5'b11100, 5'b10001);
    @(posedge clk); #1;
    chk("ocupado_e1", ocupado, 1);
    A_valor = '0; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    chk("iso_no_second_run", ocupado, 0);
    chk("iso_hold", {A_mayor, B_mayor, iguales}, 3'b100);

    // Reset between E2 and E3 of a K-cycle comparison
    start(5'b10101, 5'b10100);
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("abort_ocupado", ocupado, 0);
    chk("abort_listo", listo, 0);
    chk("abort_flags", {A_mayor, B_mayor, iguales}, 0);
    sb.delete();
    last_exp = 3'b000;
    repeat (3) @(negedge clk);
    chk("abort_still_idle", {ocupado, listo}, 0);
    reset_n = 1'b1;
    run(5'b00001, 5'b00010);

    // Back-to-back: each start lands on the first ESPERA cycle after listo
    run(5'b11100, 5'b01101);
    run(5'b10001, 5'b10110);
    run(5'b01100, 5'b10001);
    run(5'b10101, 5'b10100);
    run(5'b10101, 5'b10101);

    repeat (3) @(negedge clk);
    chk("final_hold", {A_mayor, B_mayor, iguales}, last_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
